clint_timer: RTL

- Machine-mode timer and software-interrupt source: the transmit end of the xint_mtip / xint_msip lines consumed by the write-back stage's exception/interrupt logic.
- Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a 1-bit msip, all memory-mapped on the data-memory side bus.
- Drives registered interrupt-pending levels to the core.

---
 rtl/clint_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - machine timer (mtime/mtimecmp) and software interrupt source
module clint_timer #(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam logic [31:0] OFF_MSIP     = 32'h0000_0000;
  localparam logic [31:0] OFF_MTCMP_LO = 32'h0000_4000;
  localparam logic [31:0] OFF_MTCMP_HI = 32'h0000_4004;
  localparam logic [31:0] OFF_MTIME_LO = 32'h0000_BFF8;
  localparam logic [31:0] OFF_MTIME_HI = 32'h0000_BFFC;
  localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtcmp_q, mtcmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_d;
  logic        tick;

  logic [31:0] off;
  logic        below_base, misaligned;
  logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
  logic        mapped, acc_ok, acc_err, wr;

  // Lane-wise merge of write data into an existing word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode: offsets below the base wrap to huge values, so they are rejected explicitly
  always_comb begin
    off         = addr_i - BASE_ADDR;
    below_base  = addr_i < BASE_ADDR;
    misaligned  = addr_i[1:0] != 2'b00;
    hit_msip    = off == OFF_MSIP;
    hit_cmp_lo  = off == OFF_MTCMP_LO;
    hit_cmp_hi  = off == OFF_MTCMP_HI;
    hit_time_lo = off == OFF_MTIME_LO;
    hit_time_hi = off == OFF_MTIME_HI;
    mapped      = !below_base && !misaligned &&
                  (hit_msip || hit_cmp_lo || hit_cmp_hi || hit_time_lo || hit_time_hi);
    acc_ok      = req_i && mapped;
    acc_err     = req_i && !mapped;
    wr          = acc_ok && we_i;
  end

  // Prescaler and next-state of the timer, compare and msip registers
  always_comb begin
    tick    = presc_q == TICK_LAST;
    presc_d = tick ? 16'd0 : presc_q + 16'd1;

    mtime_d = mtime_q + {63'd0, tick};
    if (wr && hit_time_lo) begin
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_i, sel_i)};
    end else if (wr && hit_time_hi) begin
      mtime_d = {merge_bytes(mtime_q[63:32], wdata_i, sel_i), mtime_q[31:0]};
    end

    mtcmp_d = mtcmp_q;
    if (wr && hit_cmp_lo) begin
      mtcmp_d[31:0] = merge_bytes(mtcmp_q[31:0], wdata_i, sel_i);
    end else if (wr && hit_cmp_hi) begin
      mtcmp_d[63:32] = merge_bytes(mtcmp_q[63:32], wdata_i, sel_i);
    end

    msip_d = msip_q;
    if (wr && hit_msip && sel_i[0]) begin
      msip_d = wdata_i[0];
    end
  end

  // Read mux samples register values before this edge's update
  always_comb begin
    rdata_d = 32'd0;
    if (acc_ok && !we_i) begin
      if (hit_msip)         rdata_d = {31'd0, msip_q};
      else if (hit_cmp_lo)  rdata_d = mtcmp_q[31:0];
      else if (hit_cmp_hi)  rdata_d = mtcmp_q[63:32];
      else if (hit_time_lo) rdata_d = mtime_q[31:0];
      else                  rdata_d = mtime_q[63:32];
    end
  end

  // State, bus response and interrupt registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q     <= 16'd0;
      mtime_q     <= 64'd0;
      mtcmp_q     <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      rdata_o     <= 32'd0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      xint_mtip_o <= 1'b0;
      xint_msip_o <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtcmp_q     <= mtcmp_d;
      msip_q      <= msip_d;
      rdata_o     <= rdata_d;
      ack_o       <= acc_ok;
      err_o       <= acc_err;
      xint_mtip_o <= mtime_d >= mtcmp_d;
      xint_msip_o <= msip_q;
    end
  end

endmodule
